// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes, fetch-state type and decode helper
// Opcode constants mirror the upper nibble of each instruction byte.
package cpu_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 8;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_XRA  = 4'b0110;
  localparam logic [3:0] OP_CMP  = 4'b0111;
  localparam logic [3:0] OP_BR   = 4'b1000;
  localparam logic [3:0] OP_MOVR = 4'b1001;
  localparam logic [3:0] OP_MOVA = 4'b1010;
  localparam logic [3:0] OP_RET  = 4'b1011;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

  // Opcodes resolved inside the fetch stage and never handed to execute.
  function automatic logic is_ctrl_flow(input logic [3:0] op);
    return (op == OP_BR) || (op == OP_RET) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch/issue stage with local BR/RET/HALT resolution
// Non-control-flow bytes are issued to execute over an ir_valid/ir_ready handshake.
module fetch_unit #(
  parameter int                 ADDR_W   = cpu_pkg::ADDR_W,
  parameter int                 INSTR_W  = cpu_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  adr,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               flag,
  input  logic               flag_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);
  import cpu_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               ir_valid_q, ir_valid_d;

  logic [3:0]         opcode;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  target;
  logic               fetch_go;

  // Next-PC candidates: sequential (wraps modulo 2^ADDR_W) and zero-extended nibble target.
  assign opcode = instr[INSTR_W-1 -: 4];
  assign pc_inc = pc_q + ADDR_W'(1);
  assign target = ADDR_W'(instr[3:0]);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    fetch_go   = 1'b0;

    case (state_q)
      FETCH:   fetch_go = 1'b1;
      ISSUE:   fetch_go = ir_ready;
      default: fetch_go = 1'b0;
    endcase

    if (fetch_go) begin
      ir_valid_d = 1'b0;
      state_d    = FETCH;
      if (!is_ctrl_flow(opcode)) begin
        ir_d       = instr;
        ir_valid_d = 1'b1;
        pc_d       = pc_inc;
        state_d    = ISSUE;
      end else if (opcode == OP_HALT) begin
        state_d = HALTED;
      end else if (opcode == OP_RET) begin
        pc_d = target;
      end else if (flag_valid) begin
        pc_d = flag ? target : pc_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign adr      = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign halted   = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with a behavioural reference
// The reference tracks "pending issue" and "halted" directly from the instruction rules.
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [4:0] adr;
  logic [7:0] instr;
  logic [7:0] ir;
  logic       ir_valid;
  logic       ir_ready = 1'b1;
  logic       flag = 1'b0;
  logic       flag_valid = 1'b1;
  logic [4:0] pc;
  logic       halted;

  logic [7:0] mem [32];
  int         n_vec = 0;
  int         n_err = 0;
  logic       chk_en = 1'b0;

  logic [4:0] m_pc;
  logic [7:0] m_ir;
  logic       m_pend;
  logic       m_halt;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .adr        (adr),
    .instr      (instr),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .flag       (flag),
    .flag_valid (flag_valid),
    .pc         (pc),
    .halted     (halted)
  );

  assign instr = mem[adr];

  always #5 clk = ~clk;

  // Reference: one step per edge, taken whenever nothing is waiting on execute.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc   <= 5'd0;
      m_ir   <= 8'h00;
      m_pend <= 1'b0;
      m_halt <= 1'b0;
    end else if (!m_halt && (!m_pend || ir_ready)) begin
      automatic logic [7:0] b = mem[m_pc];
      automatic logic [4:0] t = {1'b0, b[3:0]};
      m_pend <= 1'b0;
      if (b[7:4] == 4'hF)
        m_halt <= 1'b1;
      else if (b[7:4] == 4'hB)
        m_pc <= t;
      else if (b[7:4] == 4'h8) begin
        if (flag_valid) m_pc <= flag ? t : (m_pc + 5'd1);
      end else begin
        m_ir   <= b;
        m_pend <= 1'b1;
        m_pc   <= m_pc + 5'd1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model.adr", 32'(adr), 32'(m_pc));
      chk("model.pc", 32'(pc), 32'(m_pc));
      chk("model.ir_valid", 32'(ir_valid), 32'(m_pend));
      chk("model.ir", 32'(ir), 32'(m_ir));
      chk("model.halted", 32'(halted), 32'(m_halt));
    end
  end

  task automatic clear_mem(input logic [7:0] fill);
    for (int i = 0; i < 32; i++) mem[i] = fill;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] rdy_pat;
    logic [31:0] fv_pat;
    logic [31:0] fl_pat;

    clear_mem(8'h00);
    mem[0] = 8'h93; mem[1] = 8'h16; mem[2] = 8'h27;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("reset.pc", 32'(pc), 32'd0);
    chk("reset.adr", 32'(adr), 32'd0);
    chk("reset.ir", 32'(ir), 32'h00);
    chk("reset.ir_valid", 32'(ir_valid), 32'd0);
    chk("reset.halted", 32'(halted), 32'd0);

    // Straight-line issue at full rate
    rst_n = 1'b1;
    cycles(1); chk("line.ir0", 32'(ir), 32'h93); chk("line.v0", 32'(ir_valid), 32'd1);
    cycles(1); chk("line.ir1", 32'(ir), 32'h16);
    cycles(1); chk("line.ir2", 32'(ir), 32'h27); chk("line.pc", 32'(pc), 32'd3);

    // Backpressure with 0x16 held
    do_reset();
    cycles(2);
    ir_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycles(1);
      chk("bp.ir", 32'(ir), 32'h16);
      chk("bp.v", 32'(ir_valid), 32'd1);
      chk("bp.pc", 32'(pc), 32'd2);
    end
    ir_ready = 1'b1;
    cycles(1); chk("bp.next", 32'(ir), 32'h27); chk("bp.pc3", 32'(pc), 32'd3);

    // Branch taken / not taken at address 5
    clear_mem(8'h00);
    mem[4] = 8'h7A; mem[5] = 8'h8B;
    flag_valid = 1'b1; flag = 1'b1;
    do_reset();
    cycles(5); chk("brt.ir", 32'(ir), 32'h7A);
    cycles(1); chk("brt.pc", 32'(pc), 32'd11); chk("brt.v", 32'(ir_valid), 32'd0);
    chk("brt.ir_keep", 32'(ir), 32'h7A);
    flag = 1'b0;
    do_reset();
    cycles(6); chk("brn.pc", 32'(pc), 32'd6); chk("brn.v", 32'(ir_valid), 32'd0);

    // Branch stall then release
    flag_valid = 1'b0; flag = 1'b1;
    do_reset();
    cycles(6);
    for (int i = 0; i < 3; i++) begin
      chk("stall.pc", 32'(pc), 32'd5);
      chk("stall.v", 32'(ir_valid), 32'd0);
      if (i < 2) cycles(1);
    end
    flag_valid = 1'b1;
    cycles(1); chk("stall.rel", 32'(pc), 32'd11);

    // Return
    clear_mem(8'h00);
    mem[0] = 8'hB6; mem[6] = 8'h55;
    do_reset();
    cycles(1); chk("ret.pc", 32'(pc), 32'd6); chk("ret.v", 32'(ir_valid), 32'd0);
    cycles(1); chk("ret.ir", 32'(ir), 32'h55); chk("ret.pc7", 32'(pc), 32'd7);

    // Halt at address 30
    clear_mem(8'h00);
    mem[30] = 8'hFF;
    do_reset();
    cycles(31);
    for (int i = 0; i < 10; i++) begin
      chk("halt.h", 32'(halted), 32'd1);
      chk("halt.pc", 32'(pc), 32'd30);
      chk("halt.v", 32'(ir_valid), 32'd0);
      chk("halt.ir", 32'(ir), 32'h00);
      cycles(1);
    end

    // PC wrap with all-NOP memory
    clear_mem(8'h00);
    do_reset();
    cycles(31); chk("wrap.pc31", 32'(pc), 32'd31);
    cycles(1); chk("wrap.pc0", 32'(pc), 32'd0); chk("wrap.h", 32'(halted), 32'd0);

    // Asynchronous reset while issuing
    clear_mem(8'h00);
    mem[0] = 8'h93; mem[1] = 8'h16; mem[2] = 8'h27;
    do_reset();
    cycles(2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.pc", 32'(pc), 32'd0);
    chk("arst.adr", 32'(adr), 32'd0);
    chk("arst.v", 32'(ir_valid), 32'd0);
    chk("arst.ir", 32'(ir), 32'h00);
    chk("arst.h", 32'(halted), 32'd0);
    cycles(1);
    rst_n = 1'b1;
    cycles(1); chk("arst.restart", 32'(ir), 32'h93); chk("arst.pc1", 32'(pc), 32'd1);

    // Mixed program under irregular ready/flag patterns
    clear_mem(8'h00);
    mem[0] = 8'h11; mem[1] = 8'h72; mem[2] = 8'h85; mem[3] = 8'h33;
    mem[4] = 8'hB9; mem[5] = 8'h44; mem[6] = 8'h84; mem[9] = 8'h55;
    mem[10] = 8'hF0;
    rdy_pat = 32'hB6D9_3A75;
    fv_pat  = 32'h5F3C_E9A1;
    fl_pat  = 32'h9A6C_3355;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      ir_ready   = rdy_pat[i];
      flag_valid = fv_pat[i];
      flag       = fl_pat[i];
      cycles(1);
    end
    ir_ready = 1'b1; flag_valid = 1'b1;
    cycles(20);
    chk("mix.halted", 32'(halted), 32'd1);
    chk("mix.pc", 32'(pc), 32'd10);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and issue stage of the 8-bit processor. Drives the address of the 32×8 combinational instruction memory and registers the returned byte into an instruction register. Resolves the control-flow opcodes (BR, RET, HALT) locally. Hands every other instruction to the execute stage over a valid/ready handshake.

## Interface
- ADDR_W, 5: program counter / memory address width
- INSTR_W, 8: instruction width; upper nibble is opcode, lower nibble is operand
- RESET_PC, 0: PC value loaded at reset
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- adr  out  ADDR_W  instruction memory address, always equal to pc
- instr  in  INSTR_W  memory data; combinational from adr, valid in the same cycle
- ir  out  INSTR_W  instruction presented to execute
- ir_valid  out  1  ir holds an unissued instruction
- ir_ready  in  1  execute accepts ir this cycle
- flag  in  1  branch condition from execute (result of the last CMP)
- flag_valid  in  1  flag reflects every instruction accepted so far
- pc  out  ADDR_W  current program counter
- halted  out  1  HALT has been fetched

## Operation
- Opcode decode uses instr[7:4]:
  - 1000 = BR
  - 1011 = RET
  - 1111 = HALT
  - all other opcodes are "issue" class, including the unused 0100 and 1100–1110. They pass through unchanged; execute treats them as NOP.
- Branch/return target = {1'b0, instr[3:0]}, zero-extended to ADDR_W, so reachable targets are 0–15.
- FSM states: FETCH, ISSUE, HALTED.
- A fetch step (performed in FETCH, or in ISSUE on handshake) behaves by opcode:
  - Issue class: ir ← instr, ir_valid ← 1, pc ← pc+1, go to ISSUE.
  - BR with flag_valid=1: pc ← target if flag=1, else pc+1. ir_valid ← 0, stay in FETCH. BR is never issued.
  - BR with flag_valid=0: stall. pc unchanged, ir_valid ← 0, stay in FETCH.
  - RET: pc ← target unconditionally, ir_valid ← 0, stay in FETCH. RET is never issued.
  - HALT: pc unchanged, ir_valid ← 0, halted ← 1, go to HALTED.
- ISSUE:
  - ir_ready=0: hold ir, ir_valid and pc stable.
  - ir_ready=1: handshake completes and the fetch step runs in the same cycle (back-to-back issue).
- HALTED: absorbing state. No fetch, ir_valid=0, pc frozen. Exit only via rst_n.
- PC arithmetic is modulo 2^ADDR_W: pc=31 incremented gives 0.
- The HALT byte is never presented on ir.

## Timing
- Reset values: pc=RESET_PC, adr=RESET_PC, ir=8'h00, ir_valid=0, halted=0, state=FETCH.
- Reset mid-operation: every output returns to its reset value immediately (asynchronous). A pending ir is discarded.
- Latency:
  - The first instruction after reset deassertion appears on ir with ir_valid=1 one clock edge later.
  - Sustained throughput is one issued instruction per cycle while ir_ready=1.
- BR, RET and a non-stalled BR each cost one cycle with ir_valid=0. A stalled BR adds one cycle per cycle of flag_valid=0.
- ir and ir_valid change only:
  - on a handshake, or
  - on a fetch from FETCH state.
- Once asserted, ir_valid never drops without a handshake, except on reset.
- flag and flag_valid are sampled only in the cycle the BR is resolved.

## Structure
- Shared package cpu_pkg holds:
  - ADDR_W and INSTR_W constants
  - the opcode constants (NOP-class 0000, ADD 0001, SUB 0010, MUL 0011, AND 0101, XRA 0110, CMP 0111, BR 1000, MOVR 1001, MOVA 1010, RET 1011, HALT 1111)
  - the fetch-state enum
  - an is_ctrl_flow() decode function
- Single module, no sub-module. Next-PC selection is a small combinational block inside fetch_unit.

## Test plan
- Straight-line: program 0x93,0x16,0x27 at 0–2, ir_ready=1 → ir shows 93,16,27 on three consecutive cycles; pc reaches 3.
- Backpressure: ir_ready=0 for 4 cycles with 0x16 in ir → ir, ir_valid=1 and pc stay stable; first cycle with ir_ready=1 → next byte presented.
- Branch taken/not-taken: 0x7A then 0x8B at address 5, flag_valid=1 with flag=1 → pc=11 and 0x8B never on ir; repeat with flag=0 → pc=6.
- Branch stall and return:
  - flag_valid held 0 for 3 cycles on a BR → pc frozen, ir_valid=0 throughout; releasing flag_valid resolves the BR.
  - 0xB6 → pc=6 next cycle.
- Halt and wrap:
  - 0xFF at address 30 → halted=1, pc=30, ir_valid=0 for 10+ cycles.
  - With no HALT and all-NOP memory, pc wraps 31→0.
- Async reset: assert rst_n=0 mid-cycle while in ISSUE → pc=0, ir_valid=0 and halted=0 before the next edge; fetch restarts at 0.
